// File: rtl/collatz_arb.sv
// collatz_arb
// Round-robin arbiter and sequencer sharing one Collatz iterator between two
// requesters. A granted start value is loaded into the iterator with a
// one-cycle go pulse, then iteration steps are counted until the iterator
// reports done (or the counter saturates). The step count is returned to the
// winner together with a one-cycle ack.
//
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   req0/n0, req1/n1    level requests with their start values
//   ack0/count0         one-cycle ack and held result for requester 0
//   ack1/count1         one-cycle ack and held result for requester 1
//   busy                high whenever the sequencer is not idle
//   cgo, cn             iterator go pulse and start value
//   cdone               iterator done (its value equals 1)
module collatz_arb #(
    parameter int                N_BITS     = 32,
    parameter int                C_BITS     = 16,
    parameter logic [C_BITS-1:0] ZERO_COUNT = {C_BITS{1'b1}}
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic [N_BITS-1:0] n0,
    output logic              ack0,
    output logic [C_BITS-1:0] count0,
    input  logic              req1,
    input  logic [N_BITS-1:0] n1,
    output logic              ack1,
    output logic [C_BITS-1:0] count1,
    output logic              busy,
    output logic              cgo,
    output logic [N_BITS-1:0] cn,
    input  logic              cdone
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic                grant_reg, grant_next;
    // Id of the requester granted last; reset to 1 so requester 0 wins the
    // first contested arbitration.
    logic                ptr_reg, ptr_next;
    logic [C_BITS-1:0]   step_reg, step_next;
    logic [N_BITS-1:0]   cn_reg, cn_next;
    logic [C_BITS-1:0]   step_inc;
    logic                load_count;

    assign step_inc = step_reg + C_BITS'(1);

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        ptr_next   = ptr_reg;
        step_next  = step_reg;
        cn_next    = cn_reg;
        case (state_reg)
            IDLE: begin
                if (req0 || req1) begin
                    grant_next = (req0 && req1) ? ~ptr_reg : req1;
                    cn_next    = grant_next ? n1 : n0;
                    if (cn_next == '0) begin
                        // Zero never reaches 1: skip the iterator entirely.
                        step_next  = ZERO_COUNT;
                        state_next = RESP;
                    end else begin
                        step_next  = '0;
                        state_next = LOAD;
                    end
                end
            end
            LOAD: begin
                state_next = RUN;
            end
            RUN: begin
                if (cdone) begin
                    state_next = RESP;
                end else begin
                    step_next = step_inc;
                    // Reaching all-ones is a timeout; the count stays there.
                    if (step_inc == {C_BITS{1'b1}}) begin
                        state_next = RESP;
                    end
                end
            end
            RESP: begin
                ptr_next   = grant_reg;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            grant_reg <= 1'b0;
            ptr_reg   <= 1'b1;
            step_reg  <= '0;
            cn_reg    <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            ptr_reg   <= ptr_next;
            step_reg  <= step_next;
            cn_reg    <= cn_next;
        end
    end

    // The result register is written on the edge that enters RESP so that the
    // count is already valid during the ack cycle.
    assign load_count = (state_next == RESP) && (state_reg != RESP);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            logic [C_BITS-1:0] count_reg;
            logic              ack;

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    count_reg <= '0;
                end else if (load_count && (grant_next == 1'(gi))) begin
                    count_reg <= step_next;
                end
            end

            assign ack = (state_reg == RESP) && (grant_reg == 1'(gi));
        end
    endgenerate

    assign ack0   = g_req[0].ack;
    assign ack1   = g_req[1].ack;
    assign count0 = g_req[0].count_reg;
    assign count1 = g_req[1].count_reg;
    assign busy   = (state_reg != IDLE);
    assign cgo    = (state_reg == LOAD);
    assign cn     = cn_reg;

endmodule

// File: tb/tb_collatz_arb.sv
// tb_collatz_arb
// Drives collatz_arb with directed and randomized requests, models the Collatz
// iterator it controls, and compares every output on every cycle against a
// transaction-level reference (grant order, per-transaction latency and the
// Collatz step count computed arithmetically).
module tb_collatz_arb;
    localparam int N_BITS = 32;
    localparam int C_BITS = 16;
    localparam int SAT    = 65535;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              req0 = 1'b0, req1 = 1'b0;
    logic [N_BITS-1:0] n0 = '0, n1 = '0;
    logic              ack0, ack1, busy, cgo, cdone;
    logic [C_BITS-1:0] count0, count1;
    logic [N_BITS-1:0] cn;

    collatz_arb #(.N_BITS(N_BITS), .C_BITS(C_BITS), .ZERO_COUNT(16'hFFFF)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .n0(n0), .ack0(ack0), .count0(count0),
        .req1(req1), .n1(n1), .ack1(ack1), .count1(count1),
        .busy(busy), .cgo(cgo), .cn(cn), .cdone(cdone)
    );

    always #5 clk = ~clk;

    // Iterator: loads on go, then one Collatz step per cycle until done.
    logic [N_BITS-1:0] it_val = '0;
    bit                stuck = 1'b0;
    always @(posedge clk) begin
        if (cgo) it_val <= cn;
        else if (!cdone) it_val <= it_val[0] ? it_val * 3 + 1 : it_val >> 1;
    end
    assign cdone = !stuck && (it_val == 1);

    int checks = 0;
    int errors = 0;
    int printed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (printed < 40) begin
                printed++;
                $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
            end
        end
    endtask

    // Steps for n to reach 1, saturating; zero maps to the zero count.
    function automatic int ref_count(input longint unsigned n, input bit stk);
        longint unsigned v;
        int k;
        v = n;
        k = 0;
        if (n == 0) return 32'hFFFF;
        while (k < SAT && (stk || v != 1)) begin
            v = v[0] ? 3 * v + 1 : v >> 1;
            k++;
        end
        return k;
    endfunction

    // Cycles from the arbitration edge to the ack cycle.
    function automatic int ref_latency(input longint unsigned n, input int k);
        if (n == 0) return 1;
        if (k >= SAT) return 2 + SAT;
        return 3 + k;
    endfunction

    // Transaction-level reference state.
    bit                m_busy = 1'b0;
    bit                m_id = 1'b0;
    bit                m_ptr = 1'b1;
    bit                m_go = 1'b0;
    int                m_e = 0;
    int                m_done_at = 0;
    logic [C_BITS-1:0] m_cnt = '0;
    logic [N_BITS-1:0] m_cn = '0;
    logic [C_BITS-1:0] e_count0 = '0, e_count1 = '0;

    task automatic model_update();
        if (!reset_n) begin
            m_busy = 1'b0;
            m_ptr = 1'b1;
            m_cn = '0;
            e_count0 = '0;
            e_count1 = '0;
        end else if (m_busy) begin
            if (m_e == m_done_at) begin
                m_busy = 1'b0;
                m_ptr = m_id;
            end else begin
                m_e++;
            end
        end else if (req0 || req1) begin
            m_id = (req0 && req1) ? !m_ptr : req1;
            m_cn = m_id ? n1 : n0;
            m_go = (m_cn != 0);
            m_cnt = C_BITS'(ref_count(m_cn, stuck));
            m_done_at = ref_latency(m_cn, ref_count(m_cn, stuck));
            m_e = 1;
            m_busy = 1'b1;
        end
        if (m_busy && m_e == m_done_at) begin
            if (m_id) e_count1 = m_cnt;
            else e_count0 = m_cnt;
        end
    endtask

    task automatic compare();
        bit e_ack;
        e_ack = m_busy && (m_e == m_done_at);
        chk("ack0", ack0, e_ack && !m_id);
        chk("ack1", ack1, e_ack && m_id);
        chk("ack_overlap", ack0 & ack1, 0);
        chk("count0", count0, e_count0);
        chk("count1", count1, e_count1);
        chk("busy", busy, m_busy);
        chk("cgo", cgo, m_busy && m_go && (m_e == 1));
        chk("cn", cn, m_cn);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_update();
            #1;
            compare();
        end
    end

    // Issue one request from an idle DUT; return cycles until its ack.
    task automatic run_one(input bit id, input logic [N_BITS-1:0] n, input int bound, output int lat);
        @(negedge clk);
        if (id) begin req1 = 1'b1; n1 = n; end
        else begin req0 = 1'b1; n0 = n; end
        lat = -1;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk);
            if (id ? ack1 : ack0) begin
                lat = i;
                break;
            end
        end
        if (id) req1 = 1'b0;
        else req0 = 1'b0;
    endtask

    task automatic apply_reset(input int cycles);
        reset_n = 1'b0;
        repeat (cycles) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int lat;
        int nacks;
        int order [4];
        int exp_order [4];
        bit seen;
        exp_order = '{0, 1, 0, 1};

        // Pin the reference arithmetic with hand-computed values.
        chk("ref_steps_6", ref_count(6, 0), 8);
        chk("ref_steps_27", ref_count(27, 0), 111);
        chk("ref_steps_7", ref_count(7, 0), 16);
        chk("ref_steps_1", ref_count(1, 0), 0);
        chk("ref_lat_6", ref_latency(6, ref_count(6, 0)), 11);

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_cgo", cgo, 0);
        chk("rst_count0", count0, 0);
        chk("rst_cn", cn, 0);
        reset_n = 1'b1;

        run_one(0, 6, 200, lat);
        $display("txn req0 n=6 lat=%0d count0=%0d", lat, count0);
        chk("lat_n6", lat, 11);
        chk("count0_n6", count0, 8);

        run_one(1, 27, 300, lat);
        $display("txn req1 n=27 lat=%0d count1=%0d", lat, count1);
        chk("lat_n27", lat, 114);
        chk("count1_n27", count1, 111);

        // Both requesters held continuously: alternation starting at 0.
        @(negedge clk);
        apply_reset(2);
        req0 = 1'b1; n0 = 7; req1 = 1'b1; n1 = 1;
        nacks = 0;
        for (int i = 0; i < 400 && nacks < 4; i++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                order[nacks] = ack1 ? 1 : 0;
                $display("txn both ack id=%0d count=%0d", order[nacks], ack1 ? count1 : count0);
                nacks++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("both_nacks", nacks, 4);
        for (int i = 0; i < 4; i++) chk("both_order", order[i], exp_order[i]);
        chk("both_count0", count0, 16);
        chk("both_count1", count1, 0);

        run_one(0, 0, 20, lat);
        $display("txn req0 n=0 lat=%0d count0=%0h", lat, count0);
        chk("lat_n0", lat, 1);
        chk("count0_n0", count0, 16'hFFFF);

        // Reset in the middle of RUN discards the result.
        @(negedge clk);
        req0 = 1'b1; n0 = 27;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (ack0) seen = 1'b1;
        end
        reset_n = 1'b0; req0 = 1'b0;
        @(negedge clk);
        if (ack0) seen = 1'b1;
        reset_n = 1'b1;
        $display("txn mid-run reset ack_seen=%0d busy=%0d", seen, busy);
        chk("midrst_no_ack", seen, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_cgo", cgo, 0);
        chk("midrst_count0", count0, 0);
        run_one(0, 6, 200, lat);
        $display("txn req0 n=6 after reset lat=%0d count0=%0d", lat, count0);
        chk("post_rst_lat", lat, 11);
        chk("post_rst_count0", count0, 8);

        // Randomized traffic; the per-cycle compare does the checking.
        for (int cyc = 0; cyc < 2500; cyc++) begin
            @(negedge clk);
            if (req0) begin
                if (ack0) begin
                    $display("txn rand ack0 count0=%0d", count0);
                    if ($urandom % 2 == 0) req0 = 1'b0;
                end
            end else if ($urandom % 4 == 0) begin
                n0 = ($urandom % 8 == 0) ? 0 : $urandom_range(1, 3000);
                req0 = 1'b1;
            end
            if (req1) begin
                if (ack1) begin
                    $display("txn rand ack1 count1=%0d", count1);
                    if ($urandom % 2 == 0) req1 = 1'b0;
                end
            end else if ($urandom % 4 == 0) begin
                n1 = ($urandom % 8 == 0) ? 0 : $urandom_range(1, 3000);
                req1 = 1'b1;
            end
        end
        // Drain: release each request only after its ack.
        for (int i = 0; i < 2000 && (req0 || req1 || busy); i++) begin
            @(negedge clk);
            if (ack0) req0 = 1'b0;
            if (ack1) req1 = 1'b0;
        end
        chk("drain_idle", busy || req0 || req1, 0);

        // Iterator that never finishes: counter saturates.
        @(negedge clk);
        stuck = 1'b1;
        run_one(1, 5, 70000, lat);
        $display("txn req1 stuck lat=%0d count1=%0h", lat, count1);
        chk("sat_lat", lat, 65537);
        chk("sat_count1", count1, 16'hFFFF);
        @(negedge clk);
        chk("sat_idle", busy, 0);
        stuck = 1'b0;

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/collatz_arb.md
Name: collatz_arb

Overview:
- Round-robin arbiter and sequencer that shares one Collatz iterator between two requesters.
- Each requester submits a 32-bit start value. The block grants the iterator, pulses its go, and counts iteration steps until the iterator signals done.
- It returns a 16-bit step count to the winning requester with a one-cycle ack.
- Sits between the range-fill logic or host interface (requesters) and the collatz iterator instance.

Parameters:
- N_BITS, 32, width of start values and of the iterator n input
- C_BITS, 16, width of step counter and returned counts
- ZERO_COUNT, 16'hFFFF, count returned for n == 0 (iterator not started)

Ports:
- clk  input  1  clock
- reset_n  input  1  synchronous active-low reset
- req0  input  1  requester 0 request (level)
- n0  input  N_BITS  requester 0 start value; stable while req0 high
- ack0  output  1  one-cycle pulse; count0 valid
- count0  output  C_BITS  requester 0 result
- req1  input  1  requester 1 request (level)
- n1  input  N_BITS  requester 1 start value
- ack1  output  1  one-cycle pulse; count1 valid
- count1  output  C_BITS  requester 1 result
- busy  output  1  high in any state other than IDLE
- cgo  output  1  iterator go
- cn  output  N_BITS  iterator start value
- cdone  input  1  iterator done (value == 1)

Behaviour:
- Clock and reset: one clock, clk; reset_n is synchronous, active-low.
- Reset values: state IDLE, ack0/ack1 0, count0/count1 0, cgo 0, cn 0, busy 0, step counter 0, round-robin pointer favours requester 0.
- Iterator contract: cgo high at an edge loads cn. From the next cycle the iterator advances one Collatz step per cycle while cdone is low. cdone is combinational from the iterator value.
- FSM states: IDLE, LOAD, RUN, RESP.
- IDLE, arbitration:
  - Only req0 high: grant 0. Only req1 high: grant 1.
  - Both high: grant the requester not granted last (pointer); after reset, requester 0 wins.
  - On grant: latch grant id, latch n into cn, clear step counter.
  - Latched n == 0: go to RESP with count = ZERO_COUNT; the iterator is never started.
  - Latched n != 0: go to LOAD.
- LOAD: cgo = 1 for exactly this one cycle; go to RUN.
- RUN, each cycle:
  - cdone high: go to RESP; counter unchanged.
  - Otherwise counter += 1.
  - Counter reaching all-ones saturates; go to RESP with count all-ones (timeout).
- RESP:
  - ack of granted requester = 1 for one cycle; its count register <= step counter. The other requester's ack and count are unchanged.
  - Pointer <= granted id; go to IDLE.
- count0/count1 hold their last value until the next ack to that requester.
- Latency: req sampled in IDLE at cycle t gives LOAD at t+1, first RUN at t+2, ack at t+3+k for k steps (n = 1 gives k = 0, ack at t+3). n = 0 gives ack at t+1.
- Request rules:
  - A requester still holding req in the cycle after its ack is treated as a new request at the next IDLE arbitration.
  - A req deasserted before ack is a protocol violation; behaviour is unspecified, but the FSM must still complete and return to IDLE.
- Requests arriving while busy wait; there is no queueing beyond the level req.
- cn holds the latched value through LOAD/RUN/RESP.
- ack0 and ack1 are never high in the same cycle.
- Reset mid-operation: reset_n low in any state returns to IDLE next edge with all reset values; any in-flight result is discarded with no ack.
- Arithmetic: counter is unsigned C_BITS and saturating, never wraps. Start values are unsigned N_BITS.

Test Plan:
- Reset, then req0 = 1, n0 = 6 -> cgo pulses once with cn = 6; ack0 exactly one cycle, 11 cycles after req0 sampled; count0 = 8; ack1 stays 0.
- req1 = 1, n1 = 27 -> count1 = 111; busy high from the cycle after the grant until the cycle after ack1.
- req0 and req1 both high continuously, n0 = 7, n1 = 1 after reset -> serviced in the order 0, 1, 0, 1; count0 = 16, count1 = 0; no ack overlap.
- req0 with n0 = 0 -> no cgo; ack0 one cycle after grant; count0 = 16'hFFFF.
- Iterator model with cdone stuck low, req1 -> count1 = 16'hFFFF after 65535 RUN cycles; FSM returns to IDLE.
- reset_n low for one cycle during RUN of a req0 with n0 = 27 -> no ack0; busy 0, cgo 0, count0 = 0 after reset; the next request behaves normally.
